// File: rtl/pc_irq_ctrl_pkg.sv
// Shared CPU fetch-stage constants: PC width, reset/ROM/vector defaults and IRQ id width.
package cpu_pkg;
    localparam int             ADDR_W_DEF   = 27;
    localparam logic [26:0]    PC_START_DEF = 27'h0;
    localparam logic [26:0]    ROM_BASE_DEF = 27'hC02522;
    localparam logic [26:0]    VEC_BASE_DEF = 27'h1;
    // Wide enough to index up to 32 sources.
    localparam int             IRQ_ID_W     = 5;
endpackage

// File: rtl/pc_irq_ctrl_if.sv
// Fetch-stage bus between the core and the PC / interrupt controller.
interface pc_irq_ctrl_if #(
    parameter int ADDR_W  = 27,
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = 8
);
    logic                write_back;
    logic                jump;
    logic                offset;
    logic [ADDR_W-1:0]   jump_addr;
    logic                reti;
    logic [NUM_IRQ-1:0]  irq;
    logic [NUM_IRQ-1:0]  irq_mask;
    logic [NUM_IRQ-1:0]  pend_clr;
    logic [ADDR_W-1:0]   pc_out;
    logic [ID_W-1:0]     int_id;
    logic                int_active;
    logic [NUM_IRQ-1:0]  pending;

    modport master (
        output write_back, jump, offset, jump_addr, reti, irq, irq_mask, pend_clr,
        input  pc_out, int_id, int_active, pending
    );

    modport slave (
        input  write_back, jump, offset, jump_addr, reti, irq, irq_mask, pend_clr,
        output pc_out, int_id, int_active, pending
    );
endinterface

// File: rtl/pc_irq_ctrl_irq_edge_latch.sv
// Per-source rising-edge detector with a pending flag; a new edge beats clear/take.
module irq_edge_latch (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    input  logic pend_clr,
    input  logic take,
    output logic pending
);
    logic irq_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_prev <= 1'b0;
            pending  <= 1'b0;
        end else begin
            irq_prev <= irq;
            if (irq && !irq_prev)
                pending <= 1'b1;
            else if (pend_clr || take)
                pending <= 1'b0;
        end
    end
endmodule

// File: rtl/pc_irq_ctrl.sv
// Program counter with edge-latched, masked, fixed-priority vectored interrupts and reti.
module pc_irq_ctrl
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                NUM_IRQ  = 8,
    parameter logic [ADDR_W-1:0] PC_START = ADDR_W'(PC_START_DEF),
    parameter logic [ADDR_W-1:0] ROM_BASE = ADDR_W'(ROM_BASE_DEF),
    parameter logic [ADDR_W-1:0] VEC_BASE = ADDR_W'(VEC_BASE_DEF),
    parameter int                ID_W     = 8
) (
    input  logic          clk,
    input  logic          reset,
    pc_irq_ctrl_if.slave  bus
);
    logic                wb_prev;
    logic                advance;
    logic [ADDR_W-1:0]   saved_pc;
    logic [ADDR_W-1:0]   np;
    logic [NUM_IRQ-1:0]  eligible;
    logic [NUM_IRQ-1:0]  take;
    logic                found;
    logic [IRQ_ID_W-1:0] sel;
    logic                take_en;

    assign advance  = bus.write_back && !wb_prev;
    assign eligible = bus.pending & bus.irq_mask;

    always_comb begin
        np = bus.pc_out + ADDR_W'(1);
        if (bus.jump)
            np = bus.offset ? (bus.pc_out + bus.jump_addr) : bus.jump_addr;
    end

    // Lowest index wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (!found && eligible[i]) begin
                found = 1'b1;
                sel   = IRQ_ID_W'(i);
            end
        end
    end

    assign take_en = advance && !bus.reti && !bus.int_active
                     && (bus.pc_out < ROM_BASE) && found;

    always_comb begin
        take = '0;
        for (int i = 0; i < NUM_IRQ; i++)
            take[i] = take_en && (sel == IRQ_ID_W'(i));
    end

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_src
        irq_edge_latch u_latch (
            .clk      (clk),
            .reset    (reset),
            .irq      (bus.irq[g]),
            .pend_clr (bus.pend_clr[g]),
            .take     (take[g]),
            .pending  (bus.pending[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_prev        <= 1'b0;
            bus.pc_out     <= PC_START;
            bus.int_id     <= '0;
            bus.int_active <= 1'b0;
            saved_pc       <= '0;
        end else begin
            wb_prev <= bus.write_back;
            if (advance) begin
                if (bus.reti) begin
                    bus.pc_out     <= saved_pc;
                    bus.int_active <= 1'b0;
                end else if (take_en) begin
                    saved_pc       <= np;
                    bus.pc_out     <= VEC_BASE + ADDR_W'(sel);
                    bus.int_id     <= ID_W'(sel);
                    bus.int_active <= 1'b1;
                end else begin
                    bus.pc_out <= np;
                end
            end
        end
    end
endmodule

// File: tb/tb_pc_irq_ctrl.sv
// Directed bench for pc_irq_ctrl: PC flow, priority, reti, masking, ROM gating, reset.
module tb_pc_irq_ctrl;
    localparam int ADDR_W  = 27;
    localparam int NUM_IRQ = 8;
    localparam int ID_W    = 8;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pc_irq_ctrl_if #(.ADDR_W(ADDR_W), .NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) bus ();

    pc_irq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic adv(input logic j, input logic o, input logic [ADDR_W-1:0] a, input logic r);
        bus.jump       = j;
        bus.offset     = o;
        bus.jump_addr  = a;
        bus.reti       = r;
        bus.write_back = 1'b1;
        tick();
        bus.write_back = 1'b0;
        bus.jump       = 1'b0;
        bus.offset     = 1'b0;
        bus.jump_addr  = '0;
        bus.reti       = 1'b0;
        tick();
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc, input logic [31:0] id,
                             input logic [31:0] act, input logic [31:0] pend);
        check({tag, ".pc"},     32'(bus.pc_out),     pc);
        check({tag, ".id"},     32'(bus.int_id),     id);
        check({tag, ".active"}, 32'(bus.int_active), act);
        check({tag, ".pend"},   32'(bus.pending),    pend);
    endtask

    initial begin
        reset          = 1'b1;
        bus.write_back = 1'b0;
        bus.jump       = 1'b0;
        bus.offset     = 1'b0;
        bus.jump_addr  = '0;
        bus.reti       = 1'b0;
        bus.irq        = '0;
        bus.irq_mask   = '1;
        bus.pend_clr   = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk_state("reset", 32'h0, 32'h0, 32'h0, 32'h0);

        // Sequential and jump flow
        adv(1'b0, 1'b0, '0, 1'b0); check("seq1", 32'(bus.pc_out), 32'h1);
        adv(1'b0, 1'b0, '0, 1'b0); check("seq2", 32'(bus.pc_out), 32'h2);
        adv(1'b0, 1'b0, '0, 1'b0); check("seq3", 32'(bus.pc_out), 32'h3);
        adv(1'b1, 1'b0, 27'h40, 1'b0);       check("jabs", 32'(bus.pc_out), 32'h40);
        adv(1'b1, 1'b1, 27'h7FFFFFE, 1'b0);  check("joff", 32'(bus.pc_out), 32'h3E);
        adv(1'b1, 1'b0, 27'h7FFFFFF, 1'b0);  check("jmax", 32'(bus.pc_out), 32'h7FFFFFF);
        adv(1'b0, 1'b0, '0, 1'b0);           check("wrap", 32'(bus.pc_out), 32'h0);
        adv(1'b1, 1'b0, 27'h10, 1'b0);       check("j10",  32'(bus.pc_out), 32'h10);

        // Priority and vector
        bus.irq = 8'h24;
        tick();
        check("pend24", 32'(bus.pending), 32'h24);
        adv(1'b0, 1'b0, '0, 1'b0);
        chk_state("take2", 32'h3, 32'h2, 32'h1, 32'h20);
        adv(1'b0, 1'b0, '0, 1'b0);
        chk_state("nonest", 32'h4, 32'h2, 32'h1, 32'h20);

        // Return flow: saved PC is 0x11
        adv(1'b0, 1'b0, '0, 1'b1);
        chk_state("reti1", 32'h11, 32'h2, 32'h0, 32'h20);
        adv(1'b0, 1'b0, '0, 1'b0);
        chk_state("take5", 32'h6, 32'h5, 32'h1, 32'h0);
        adv(1'b0, 1'b0, '0, 1'b1);
        chk_state("reti2", 32'h12, 32'h5, 32'h0, 32'h0);

        // Masking and clear
        bus.irq = '0;
        tick();
        bus.irq_mask = 8'hF7;
        bus.irq      = 8'h08;
        tick();
        check("pend3", 32'(bus.pending), 32'h08);
        adv(1'b0, 1'b0, '0, 1'b0);
        adv(1'b0, 1'b0, '0, 1'b0);
        adv(1'b0, 1'b0, '0, 1'b0);
        chk_state("masked", 32'h15, 32'h5, 32'h0, 32'h08);
        bus.pend_clr = 8'h08;
        tick();
        bus.pend_clr = '0;
        check("clr3", 32'(bus.pending), 32'h0);
        bus.irq_mask = '1;
        adv(1'b0, 1'b0, '0, 1'b0);
        chk_state("unmask", 32'h16, 32'h5, 32'h0, 32'h0);

        // ROM region gating
        bus.irq = '0;
        adv(1'b1, 1'b0, 27'hC02522, 1'b0);
        check("jrom", 32'(bus.pc_out), 32'hC02522);
        bus.irq = 8'h01;
        tick();
        adv(1'b0, 1'b0, '0, 1'b0);
        chk_state("rom_notake", 32'hC02523, 32'h5, 32'h0, 32'h01);
        adv(1'b1, 1'b0, 27'h5, 1'b0);
        chk_state("rom_exit", 32'h5, 32'h5, 32'h0, 32'h01);
        adv(1'b0, 1'b0, '0, 1'b0);
        chk_state("take0", 32'h1, 32'h0, 32'h1, 32'h0);
        adv(1'b0, 1'b0, '0, 1'b1);
        chk_state("reti0", 32'h6, 32'h0, 32'h0, 32'h0);

        // write_back held high gives a single advance
        bus.write_back = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        bus.write_back = 1'b0;
        tick();
        check("wb_held", 32'(bus.pc_out), 32'h7);

        // New edge beats pend_clr in the same cycle
        bus.irq      = 8'h02;
        bus.pend_clr = 8'h02;
        tick();
        bus.pend_clr = '0;
        check("edge_vs_clr", 32'(bus.pending), 32'h02);

        // Reset in the middle of a handler
        bus.irq = 8'h12;
        tick();
        adv(1'b0, 1'b0, '0, 1'b0);
        chk_state("take1", 32'h2, 32'h1, 32'h1, 32'h10);
        reset   = 1'b1;
        bus.irq = '0;
        tick();
        reset = 1'b0;
        tick();
        chk_state("mid_reset", 32'h0, 32'h0, 32'h0, 32'h0);
        adv(1'b0, 1'b0, '0, 1'b0);
        check("post_rst", 32'(bus.pc_out), 32'h1);
        adv(1'b0, 1'b0, '0, 1'b1);
        chk_state("reti_cleared", 32'h0, 32'h0, 32'h0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
